stage_fifo: RTL and testbench

STAGE_FIFO -- requirements
Module: stage_fifo

---
 rtl/ysyx_pipe_pkg.sv | 36 +++
 rtl/stage_fifo_ptr.sv | 81 ++++++++
 rtl/stage_fifo.sv | 101 ++++++++++
 tb/tb_stage_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_pipe_pkg.sv
// ============================================================================
// Module : ysyx_pipe_pkg
// Purpose: Shared pipeline constants and types. It holds the per-stage
//          payload widths, the default inter-stage FIFO depth, and the
//          push/pop operation encoding used by the FIFO pointer logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_pipe_pkg;

  // Payload widths of the pipeline stage registers
  localparam int IF_W = 64;
  localparam int ID_W = 192;
  localparam int EX_W = 109;
  localparam int LS_W = 104;

  // Default number of entries in an inter-stage FIFO
  localparam int STAGE_FIFO_DEPTH = 2;

  // Per-cycle FIFO operation. The encoding equals {push, pop}, so a
  // two-bit concatenation casts straight to this type.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_fifo_ptr.sv
// ============================================================================
// Module : stage_fifo_ptr
// Purpose: Read/write pointers and occupancy counter for stage_fifo.
// Ports  : clk, rst_n (async active-low)
//          push_i, pop_i   - effective storage push/pop this cycle
//          flush_i         - clear pointers and count at the next edge
//          wptr_o, rptr_o  - write/read pointers (modulo DEPTH)
//          count_o         - current occupancy, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_fifo_ptr
  import ysyx_pipe_pkg::*;
#(
  parameter  int DEPTH = STAGE_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [PW-1:0] wptr_o,
  output logic [PW-1:0] rptr_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so the natural PW-bit overflow is the
  // modulo-DEPTH wrap from DEPTH-1 back to 0.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      case (fifo_op(push_i, pop_i))
        OP_PUSH: begin
          wptr_d  = wptr_q + PW'(1);
          count_d = count_q + CW'(1);
        end
        OP_POP: begin
          rptr_d  = rptr_q + PW'(1);
          count_d = count_q - CW'(1);
        end
        OP_BOTH: begin
          wptr_d = wptr_q + PW'(1);
          rptr_d = rptr_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stage_fifo.sv
// ============================================================================
// Module : stage_fifo
// Purpose: Valid/ready FIFO between two pipeline stages, with flush for
//          branch redirects. Storage, optional bypass muxing and flush
//          gating live here; pointers and count live in stage_fifo_ptr.
// Ports  : clk, rst (async active-low)
//          in_valid/in_ready/in_data    - upstream handshake and payload
//          out_valid/out_ready/out_data - downstream handshake and payload
//          flush                        - discard all contents
//          count                        - current occupancy
// Config : STAGE_FIFO_BYPASS_EN - when defined, a beat arriving at an
//          empty FIFO is presented on the output in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_fifo
  import ysyx_pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = STAGE_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             stored_valid;
  logic             push;
  logic             pop;
  logic             byp_take;
  logic             push_mem;
  logic             pop_mem;

  // rst gates the handshakes so both drop immediately while reset is low.
  // in_ready depends only on state, flush and reset.
  assign in_ready     = rst && (count != CW'(DEPTH)) && !flush;
  assign stored_valid = rst && (count != CW'(0)) && !flush;

`ifdef STAGE_FIFO_BYPASS_EN
  logic byp;
  assign byp       = rst && (count == CW'(0)) && in_valid && !flush;
  assign out_valid = stored_valid || byp;
  assign out_data  = byp ? in_data : mem_q[rptr];
  // A bypassed beat taken downstream never touches storage.
  assign byp_take  = byp && out_ready;
`else
  assign out_valid = stored_valid;
  assign out_data  = mem_q[rptr];
  assign byp_take  = 1'b0;
`endif

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign push_mem = push && !byp_take;
  assign pop_mem  = pop && !byp_take;

  stage_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_mem),
    .pop_i   (pop_mem),
    .flush_i (flush),
    .wptr_o  (wptr),
    .rptr_o  (rptr),
    .count_o (count)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_mem) begin
      mem_q[wptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push_mem && count == CW'(DEPTH)));
      assert (!(pop_mem && count == CW'(0)));
      assert (count <= CW'(DEPTH));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_fifo.sv
// ============================================================================
// Module : tb_stage_fifo
// Purpose: Self-checking bench for stage_fifo with DEPTH=2, WIDTH=8.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_fifo;

  localparam int W = 8;
  localparam int D = 2;
`ifdef STAGE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         e_ir;
    logic         e_ov;
    logic         chk_od;
    logic [W-1:0] e_od;
    logic [1:0]   e_cnt;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d,
                              input logic ordy, input logic fl,
                              input logic e_ir, input logic e_ov,
                              input logic chk_od, input logic [W-1:0] e_od,
                              input logic [1:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.chk_od = chk_od;
    v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Reset with idle inputs; release away from the rising edge.
  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] popped[$];
    logic [W-1:0] q[$];

    // Directed vectors: fill, stall, pop while full, flush with offered beat
    tbl[0]  = mk(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, BYP,  BYP,  8'hA1, 2'd0);
    tbl[1]  = mk(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd1);
    for (int i = 2; i <= 6; i++)
      tbl[i] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2);
    tbl[7]  = mk(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd2);
    tbl[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, 2'd1);
    tbl[9]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, 2'd1);
    tbl[10] = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2);
    tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    tbl[12] = mk(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, BYP,  BYP,  8'h66, 2'd0);

    // Reset state while rst is held low
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
      if (tbl[i].chk_od)
        chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
      @(posedge clk);
      #1;
    end

    // Continuous streaming of 0x01..0x08
    do_reset();
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'(i + 1), 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("stream%0d_count", i), count,
          (i == 0 || BYP) ? 2'd0 : 2'd1);
      chk($sformatf("stream%0d_in_ready", i), in_ready, 1'b1);
      if (out_valid) popped.push_back(out_data);
      @(posedge clk);
      #1;
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) popped.push_back(out_data);
      @(posedge clk);
      #1;
    end
    chk("stream_beats", popped.size(), 8);
    for (int i = 0; i < popped.size() && i < 8; i++)
      chk($sformatf("stream_order%0d", i), popped[i], W'(i + 1));
    chk("stream_drained_count", count, 2'd0);

    // Beat into an empty FIFO with downstream ready
    do_reset();
    drive(1'b1, 8'h7E, 1'b1, 1'b0);
    @(negedge clk);
    chk("empty_ov_same_cycle", out_valid, BYP);
    if (out_valid) chk("empty_od_same_cycle", out_data, 8'h7E);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("empty_ov_next_cycle", out_valid, !BYP);
    chk("empty_count_next_cycle", count, {1'b0, !BYP});
    if (out_valid) chk("empty_od_next_cycle", out_data, 8'h7E);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("empty_final_count", count, 2'd0);

    // Asynchronous reset while full
    do_reset();
    drive(1'b1, 8'h21, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_before_rst_count", count, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_count", count, 2'd0);
    chk("async_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Random traffic against a queue model
    do_reset();
    q.delete();
    for (int n = 0; n < 400; n++) begin
      logic         iv, ordy, fl, byp, e_ir, e_ov;
      logic [W-1:0] d, e_od;
      iv   = ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      d    = W'($urandom);
      drive(iv, d, ordy, fl);
      @(negedge clk);
      e_ir = (q.size() != D) && !fl;
      byp  = BYP && (q.size() == 0) && iv && !fl;
      e_ov = ((q.size() != 0) && !fl) || byp;
      e_od = '0;
      if (byp) e_od = d;
      else if (q.size() != 0) e_od = q[0];
      chk("rand_in_ready", in_ready, e_ir);
      chk("rand_out_valid", out_valid, e_ov);
      chk("rand_count", count, q.size());
      if (e_ov) chk("rand_out_data", out_data, e_od);
      if (fl) begin
        q.delete();
      end else if (!(byp && ordy)) begin
        if (e_ov && ordy) void'(q.pop_front());
        if (iv && e_ir) q.push_back(d);
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
